// File: rtl/sdp_be_write_packer.sv
// sdp_be_write_packer
// Byte-stream to masked-word write packer for a byte-enabled SDP RAM write port.
// Bytes aimed at the same word are merged into one masked write. A write is
// issued on word change, full mask, s_last, or (optionally) idle timeout.
// Optional feature macro: SDP_BE_PACK_TIMEOUT_EN enables the idle-timeout flush.
module sdp_be_write_packer #(
  parameter int  WABITS    = 10,
  parameter int  WDBITS    = 32,
  parameter int  BYTEWIDTH = 8,
  parameter int  TIMEOUT   = 15,
  localparam int NBYTES    = WDBITS / BYTEWIDTH,
  localparam int LB        = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WABITS+LB-1:0] s_addr,
  input  logic [BYTEWIDTH-1:0] s_data,
  input  logic                 s_last,
  input  logic                 m_hold,
  output logic                 we,
  output logic [WABITS-1:0]    wa,
  output logic [WDBITS-1:0]    wd,
  output logic [NBYTES-1:0]    be,
  output logic                 pending,
  output logic [15:0]          wr_count
);

  typedef enum logic {ST_EMPTY, ST_ACC} state_t;

  state_t              r_state;
  logic [WABITS-1:0]   r_word;
  logic [NBYTES-1:0]   r_mask;
  logic [WDBITS-1:0]   r_data;
  logic                r_flush_next;
  logic                r_rdy_en;
  logic                r_we;
  logic [WABITS-1:0]   r_wa;
  logic [WDBITS-1:0]   r_wd;
  logic [NBYTES-1:0]   r_be;
  logic [15:0]         r_wr_count;

  logic                w_accept;
  logic                w_same;
  logic [WABITS-1:0]   w_word;
  logic [LB-1:0]       w_lane;
  logic [NBYTES-1:0]   w_lane_oh;
  logic [WDBITS-1:0]   w_lane_ins;
  logic [WDBITS-1:0]   w_lane_keep;
  logic [NBYTES-1:0]   w_mrg_mask;
  logic [WDBITS-1:0]   w_mrg_data;

  logic                w_emit;
  logic [WABITS-1:0]   w_e_wa;
  logic [NBYTES-1:0]   w_e_mask;
  logic [WDBITS-1:0]   w_e_data;
  state_t              w_nx_state;
  logic [WABITS-1:0]   w_nx_word;
  logic [NBYTES-1:0]   w_nx_mask;
  logic [WDBITS-1:0]   w_nx_data;
  logic                w_nx_flush;

`ifdef SDP_BE_PACK_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] r_timer;
  logic          w_timeout;
  assign w_timeout = (r_state == ST_ACC) && (r_timer == TW'(TIMEOUT));
`else
  // Timer absent in this build; TIMEOUT is kept only for a stable parameter list.
  logic w_timeout_unused;
  assign w_timeout_unused = (TIMEOUT != 0);
`endif

  // Input is stalled during reset recovery, while the RAM port is borrowed,
  // and for the one cycle a deferred s_last word is being flushed.
  assign s_ready  = r_rdy_en && !m_hold && !r_flush_next;
  assign w_accept = s_valid && s_ready;
  assign w_same   = (r_state == ST_ACC) && (w_word == r_word);

  // Decode the incoming beat's lane and build the merged word image.
  always_comb begin
    w_word      = s_addr[WABITS+LB-1:LB];
    w_lane      = s_addr[LB-1:0];
    w_lane_oh   = '0;
    w_lane_ins  = '0;
    w_lane_keep = '1;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (w_lane == LB'(i)) begin
        w_lane_oh[i]                          = 1'b1;
        w_lane_ins[i*BYTEWIDTH +: BYTEWIDTH]  = s_data;
        w_lane_keep[i*BYTEWIDTH +: BYTEWIDTH] = '0;
      end
    end
    // Mask/data are cleared whenever the packer empties, so merging into an
    // empty packer yields exactly the new single-byte word.
    w_mrg_mask = r_mask | w_lane_oh;
    w_mrg_data = (r_data & w_lane_keep) | w_lane_ins;
  end

  // Decide this cycle's write and the next pending word.
  always_comb begin
    w_emit     = 1'b0;
    w_e_wa     = r_word;
    w_e_mask   = r_mask;
    w_e_data   = r_data;
    w_nx_state = r_state;
    w_nx_word  = r_word;
    w_nx_mask  = r_mask;
    w_nx_data  = r_data;
    w_nx_flush = r_flush_next;
    if (r_flush_next) begin
      if (!m_hold) begin
        w_emit     = 1'b1;
        w_nx_state = ST_EMPTY;
        w_nx_mask  = '0;
        w_nx_data  = '0;
        w_nx_flush = 1'b0;
      end
    end else if (w_accept) begin
      if ((r_state == ST_EMPTY) || w_same) begin
        if ((&w_mrg_mask) || s_last) begin
          w_emit     = 1'b1;
          w_e_wa     = w_word;
          w_e_mask   = w_mrg_mask;
          w_e_data   = w_mrg_data;
          w_nx_state = ST_EMPTY;
          w_nx_mask  = '0;
          w_nx_data  = '0;
        end else begin
          w_nx_state = ST_ACC;
          w_nx_word  = w_word;
          w_nx_mask  = w_mrg_mask;
          w_nx_data  = w_mrg_data;
        end
      end else begin
        // Word change: retire the old word now; a new word that must also
        // be flushed goes out on the following cycle to keep arrival order.
        w_emit     = 1'b1;
        w_nx_state = ST_ACC;
        w_nx_word  = w_word;
        w_nx_mask  = w_lane_oh;
        w_nx_data  = w_lane_ins;
        w_nx_flush = s_last || (&w_lane_oh);
      end
    end
`ifdef SDP_BE_PACK_TIMEOUT_EN
    else if (w_timeout && !m_hold) begin
      w_emit     = 1'b1;
      w_nx_state = ST_EMPTY;
      w_nx_mask  = '0;
      w_nx_data  = '0;
    end
`endif
  end

  // Packer state and registered RAM write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_word       <= '0;
      r_mask       <= '0;
      r_data       <= '0;
      r_flush_next <= 1'b0;
      r_rdy_en     <= 1'b0;
      r_we         <= 1'b0;
      r_wa         <= '0;
      r_wd         <= '0;
      r_be         <= '0;
      r_wr_count   <= '0;
    end else begin
      r_rdy_en     <= 1'b1;
      r_state      <= w_nx_state;
      r_word       <= w_nx_word;
      r_mask       <= w_nx_mask;
      r_data       <= w_nx_data;
      r_flush_next <= w_nx_flush;
      r_we         <= w_emit;
      if (w_emit) begin
        r_wa       <= w_e_wa;
        r_be       <= w_e_mask;
        r_wd       <= w_e_data;
        r_wr_count <= r_wr_count + 16'd1;
      end else begin
        r_be       <= '0;
        r_wd       <= '0;
      end
    end
  end

`ifdef SDP_BE_PACK_TIMEOUT_EN
  // Idle timer: counts non-accepting cycles while a word is pending, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_accept || (r_state != ST_ACC)) begin
      r_timer <= '0;
    end else if (r_timer != TW'(TIMEOUT)) begin
      r_timer <= r_timer + 1'b1;
    end
  end
`endif

  assign we       = r_we;
  assign wa       = r_wa;
  assign wd       = r_wd;
  assign be       = r_be;
  assign pending  = (r_state == ST_ACC);
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_sdp_be_write_packer.sv
// Self-checking bench for sdp_be_write_packer: directed cases plus a random
// byte stream compared against a byte-shadow memory model.
module tb_sdp_be_write_packer;

  localparam int WABITS = 10;
  localparam int LB     = 2;
  localparam int AW     = WABITS + LB;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          s_valid  = 1'b0;
  logic          s_last   = 1'b0;
  logic          m_hold   = 1'b0;
  logic [AW-1:0] s_addr   = '0;
  logic [7:0]    s_data   = '0;
  logic          s_ready;
  logic          we;
  logic [9:0]    wa;
  logic [31:0]   wd;
  logic [3:0]    be;
  logic          pending;
  logic [15:0]   wr_count;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  int unsigned mon_cnt = 0;
  int unsigned bad_be = 0;
  int unsigned bad_lane = 0;

  typedef struct {
    logic [9:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    int unsigned cyc;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] ram [0:1023];
  logic [31:0] shadow [0:7];

  sdp_be_write_packer #(
    .WABITS(10),
    .WDBITS(32),
    .BYTEWIDTH(8),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_addr(s_addr),
    .s_data(s_data),
    .s_last(s_last),
    .m_hold(m_hold),
    .we(we),
    .wa(wa),
    .wd(wd),
    .be(be),
    .pending(pending),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Observe the write port mid-cycle and apply writes to the bench RAM.
  always @(negedge clk) begin : mon
    wr_t w;
    if (!rst_n) begin
      mon_cnt = 0;
    end else if (we) begin
      w.wa = wa; w.wd = wd; w.be = be; w.cyc = cyc;
      wq.push_back(w);
      mon_cnt++;
      if (be == 4'b0) bad_be++;
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[wa][i*8 +: 8] = wd[i*8 +: 8];
        else if (wd[i*8 +: 8] != 8'h00) bad_lane++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [9:0] ea,
                        input logic [3:0] eb, input logic [31:0] ed);
    chk({tag, "_present"}, (wq.size() > idx), 1'b1);
    if (wq.size() > idx) begin
      chk({tag, "_wa"}, wq[idx].wa, ea);
      chk({tag, "_be"}, wq[idx].be, eb);
      chk({tag, "_wd"}, wq[idx].wd, ed);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic put(input int unsigned word, input int unsigned lane,
                     input logic [7:0] d, input logic l);
    int unsigned n;
    n = 0;
    s_valid = 1'b1;
    s_addr  = AW'((word << LB) | lane);
    s_data  = d;
    s_last  = l;
    #1;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!s_ready) chk("put_accept", s_ready, 1'b1);
    last_acc = cyc + 1;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    int unsigned n;
    int unsigned cur_w;
    int unsigned lane;
    for (int i = 0; i < 1024; i++) ram[i] = '0;

    // Reset values
    #2;
    chk("rst_we", we, 1'b0);
    chk("rst_be", be, 4'h0);
    chk("rst_wd", wd, 32'h0);
    chk("rst_wa", wa, 10'h0);
    chk("rst_pending", pending, 1'b0);
    chk("rst_wr_count", wr_count, 16'h0);
    chk("rst_s_ready", s_ready, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Full word from four lanes
    put(16, 0, 8'hAA, 1'b0);
    put(16, 1, 8'hBB, 1'b0);
    put(16, 2, 8'hCC, 1'b0);
    put(16, 3, 8'hDD, 1'b0);
    idle(3);
    chk("t2_nwr", wq.size(), 1);
    chk_wr("t2", 0, 10'h010, 4'hF, 32'hDDCCBBAA);
    if (wq.size() > 0) chk("t2_lat", wq[0].cyc, last_acc);
    chk("t2_wr_count", wr_count, 16'd1);
    chk("t2_pending", pending, 1'b0);
    wq.delete();

    // Word change, then merge with s_last
    put(5, 0, 8'h11, 1'b0);
    put(6, 2, 8'h22, 1'b0);
    idle(2);
    chk_wr("t3a", 0, 10'd5, 4'b0001, 32'h00000011);
    put(6, 1, 8'h33, 1'b1);
    idle(2);
    chk_wr("t3b", 1, 10'd6, 4'b0110, 32'h00223300);
    chk("t3_pending", pending, 1'b0);
    chk("t3_wr_count", wr_count, 16'd3);
    wq.delete();

    // Word change together with s_last: two writes on consecutive cycles
    put(48, 0, 8'h01, 1'b0);
    put(49, 3, 8'h02, 1'b1);
    #1;
    chk("t7_ready_gap", s_ready, 1'b0);
    idle(3);
    chk_wr("t7a", 0, 10'd48, 4'b0001, 32'h00000001);
    chk_wr("t7b", 1, 10'd49, 4'b1000, 32'h02000000);
    if (wq.size() > 1) chk("t7_seq", wq[1].cyc - wq[0].cyc, 1);
    wq.delete();

    // Word address wrap, plus same-lane overwrite
    put(1023, 3, 8'h70, 1'b0);
    put(1023, 3, 8'h77, 1'b0);
    put(0, 0, 8'h88, 1'b1);
    idle(3);
    chk("t8_nwr", wq.size(), 2);
    chk_wr("t8a", 0, 10'd1023, 4'b1000, 32'h77000000);
    chk_wr("t8b", 1, 10'd0, 4'b0001, 32'h00000088);
    wq.delete();

    // Idle single byte
    put(7, 3, 8'h44, 1'b0);
`ifdef SDP_BE_PACK_TIMEOUT_EN
    n = 0;
    while (wq.size() == 0 && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk_wr("t4", 0, 10'd7, 4'b1000, 32'h44000000);
    if (wq.size() > 0) chk("t4_lat", wq[0].cyc - last_acc, 16);
`else
    idle(100);
    chk("t4_nowr", wq.size(), 0);
    chk("t4_pending", pending, 1'b1);
    put(7, 0, 8'h45, 1'b1);
    idle(2);
    chk_wr("t4", 0, 10'd7, 4'b1001, 32'h44000045);
`endif
    wq.delete();

    // m_hold while a word is pending
    put(32, 1, 8'h5A, 1'b0);
    m_hold = 1'b1;
    idle(30);
    chk("t5_ready", s_ready, 1'b0);
    chk("t5_nowr", wq.size(), 0);
    chk("t5_pending", pending, 1'b1);
`ifdef SDP_BE_PACK_TIMEOUT_EN
    @(negedge clk);
    m_hold = 1'b0;
    c = cyc;
    idle(3);
    chk_wr("t5", 0, 10'd32, 4'b0010, 32'h00005A00);
    if (wq.size() > 0) chk("t5_lat", wq[0].cyc - c, 1);
`else
    m_hold = 1'b0;
    put(32, 2, 8'h6B, 1'b1);
    idle(2);
    chk_wr("t5", 0, 10'd32, 4'b0110, 32'h006B5A00);
`endif
    wq.delete();

    // Asynchronous reset with a word pending
    put(64, 0, 8'h99, 1'b0);
    idle(1);
    chk("t1_pend_before", pending, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t1_we", we, 1'b0);
    chk("t1_be", be, 4'h0);
    chk("t1_pending", pending, 1'b0);
    chk("t1_wr_count", wr_count, 16'h0);
    chk("t1_s_ready", s_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wq.delete();
    idle(30);
    chk("t1_nowr", wq.size(), 0);
    chk("t1_pending_after", pending, 1'b0);

    // Random byte stream vs. byte-shadow memory
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 8; i++) shadow[i] = '0;
    cur_w = 0;
    for (int t = 0; t < 3000; t++) begin
      m_hold  = ($urandom_range(0, 9) == 0);
      s_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) cur_w = $urandom_range(0, 7);
      lane    = $urandom_range(0, 3);
      s_addr  = AW'((cur_w << LB) | lane);
      s_data  = 8'($urandom);
      s_last  = ($urandom_range(0, 15) == 0);
      #1;
      if (s_valid && s_ready) shadow[cur_w][lane*8 +: 8] = s_data;
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_hold  = 1'b0;
    put(0, 0, 8'h5E, 1'b1);
    shadow[0][7:0] = 8'h5E;
    idle(4);
    for (int w = 0; w < 8; w++) chk($sformatf("rnd_ram_w%0d", w), ram[w], shadow[w]);
    chk("rnd_be_nonzero", bad_be, 0);
    chk("rnd_disabled_lanes_zero", bad_lane, 0);
    chk("rnd_pending", pending, 1'b0);
    chk("rnd_wr_count", wr_count, 16'(mon_cnt));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
